// File: rtl/mfp_ahb_dma_master.sv
// AHB-lite DMA copy engine: moves len 32-bit words from src to dst using
// single, non-pipelined NONSEQ transfers (one read, then one write, per word).
module mfp_ahb_dma_master #(
  parameter int          LEN_W     = 12,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_done,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic [2:0]        state_dbg
);

  // Bus handshake: an address phase (NONSEQ) completes on the first cycle
  // with HREADY=1; the following data phase completes on the first cycle
  // with HREADY=1, where HRESP=1 marks an ERROR response.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_DATA = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t            state, state_nxt;
  logic [31:0]       src_ptr, dst_ptr, data_reg;
  logic [LEN_W-1:0]  len_reg, words_cnt;
  logic              err_reg;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      data_reg  <= '0;
      len_reg   <= '0;
      words_cnt <= '0;
      err_reg   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_ptr   <= {src_addr[31:2], 2'b00};
            dst_ptr   <= {dst_addr[31:2], 2'b00};
            len_reg   <= len;
            words_cnt <= '0;
            err_reg   <= 1'b0;
          end
        end
        S_RD_DATA: begin
          if (HREADY) begin
            if (HRESP) err_reg  <= 1'b1;
            else       data_reg <= HRDATA;
          end
        end
        S_WR_DATA: begin
          if (HREADY) begin
            if (HRESP) begin
              err_reg <= 1'b1;
            end else begin
              // Pointers wrap naturally modulo 2^32.
              words_cnt <= words_cnt + LEN_ONE;
              src_ptr   <= src_ptr + 32'd4;
              dst_ptr   <= dst_ptr + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (len == '0) ? S_FIN : S_RD_ADDR;
      S_RD_ADDR: if (HREADY) state_nxt = S_RD_DATA;
      S_RD_DATA: if (HREADY) state_nxt = HRESP ? S_FIN : S_WR_ADDR;
      S_WR_ADDR: if (HREADY) state_nxt = S_WR_DATA;
      S_WR_DATA: begin
        if (HREADY)
          state_nxt = (HRESP || (words_cnt + LEN_ONE == len_reg)) ? S_FIN : S_RD_ADDR;
      end
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs decode from state, so an async reset idles the bus at once.
  assign HTRANS     = (state == S_RD_ADDR || state == S_WR_ADDR) ? 2'b10 : 2'b00;
  assign HWRITE     = (state == S_WR_ADDR);
  assign HADDR      = (state == S_WR_ADDR || state == S_WR_DATA) ? dst_ptr : src_ptr;
  assign HWDATA     = data_reg;
  assign HSIZE      = 3'b010;
  assign HBURST     = 3'b000;
  assign HMASTLOCK  = 1'b0;
  assign HPROT      = HPROT_VAL;

  assign busy       = (state == S_RD_ADDR) || (state == S_RD_DATA) ||
                      (state == S_WR_ADDR) || (state == S_WR_DATA);
  assign done       = (state == S_FIN);
  assign error      = err_reg;
  assign words_done = words_cnt;
  assign state_dbg  = state;

endmodule

// File: tb/tb_mfp_ahb_dma_master.sv
// Bench for mfp_ahb_dma_master: a behavioural AHB slave with a sparse memory,
// an expected-transfer queue built from the copy rules, and per-job result checks.
module tb_mfp_ahb_dma_master;
  localparam int LEN_W = 12;

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  logic              start = 1'b0;
  logic [31:0]       src_addr = '0, dst_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done, error;
  logic [LEN_W-1:0]  words_done;
  logic [31:0]       HADDR, HWDATA;
  logic [1:0]        HTRANS;
  logic              HWRITE, HMASTLOCK;
  logic [2:0]        HSIZE, HBURST, state_dbg;
  logic [3:0]        HPROT;
  logic [31:0]       HRDATA = '0;
  logic              HREADY = 1'b1;
  logic              HRESP = 1'b0;

  mfp_ahb_dma_master #(.LEN_W(LEN_W), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .error(error),
    .words_done(words_done), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];     // {write, address} of each expected address phase
  logic [31:0] wd_q[$];      // expected HWDATA per expected write
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5EED_1234;
  endfunction

  // ---------------- slave model ----------------
  int          wait_mode = 0;   // 0: zero-wait, 1: two waits, 2: random 0..2
  int          err_kind  = 0;   // 0: none, 1: read error, 2: write error
  int          err_idx   = 0;
  int          rd_seen   = 0, wr_seen = 0;
  bit          ph_valid  = 0, ph_write = 0, ph_err = 0, ph_low = 0;
  logic [31:0] ph_addr   = '0, ph_wdata = '0;
  int          ph_wait   = 0;

  always @(negedge HCLK) begin
    if (HRESET) begin
      ph_valid = 0; ph_low = 0; HREADY = 1'b1; HRESP = 1'b0;
    end else if (ph_valid) begin
      chk("data_phase_htrans", 64'(HTRANS), 64'd0);
      if (ph_write) chk("hwdata", 64'(HWDATA), 64'(ph_wdata));
      if (ph_low) chk("haddr_stable", 64'(HADDR), 64'(ph_addr));
      if (ph_wait > 0) begin
        HREADY = 1'b0; HRESP = 1'b0; ph_wait--; ph_low = 1;
      end else begin
        HREADY = 1'b1; HRESP = ph_err; ph_valid = 0; ph_low = 0;
        if (!ph_write) HRDATA = ph_err ? $urandom : mem_rd(ph_addr);
        else if (!ph_err) mem[ph_addr] = HWDATA;
      end
    end else begin
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
      if (HTRANS == 2'b10) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_nonseq", {31'd0, HWRITE, HADDR}, 64'd0);
        end else begin
          chk("addr_phase", {31'd0, HWRITE, HADDR}, {31'd0, exp_q.pop_front()});
        end
        ph_valid = 1; ph_addr = HADDR; ph_write = HWRITE; ph_low = 0;
        ph_wait = (wait_mode == 1) ? 2 : (wait_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        if (HWRITE) begin
          ph_err = (err_kind == 2) && (wr_seen == err_idx);
          ph_wdata = (wd_q.size() != 0) ? wd_q.pop_front() : 32'hDEAD_BEEF;
          wr_seen++;
        end else begin
          ph_err = (err_kind == 1) && (rd_seen == err_idx);
          rd_seen++;
        end
      end
    end
  end

  // ---------------- reference model: expected transfer list ----------------
  logic [31:0] exp_data[$];
  int          exp_words;
  bit          exp_err;

  task automatic prep_job(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int ek, input int ei, input int wm);
    logic [31:0] sa, da, w;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    exp_q.delete(); wd_q.delete(); exp_data.delete();
    exp_words = n; exp_err = 0;
    err_kind = ek; err_idx = ei; wait_mode = wm; rd_seen = 0; wr_seen = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, sa + 32'(4 * i)});
      if (ek == 1 && ei == i) begin exp_err = 1; exp_words = i; break; end
      w = mem_rd(sa + 32'(4 * i));
      exp_q.push_back({1'b1, da + 32'(4 * i)});
      wd_q.push_back(w);
      if (ek == 2 && ei == i) begin exp_err = 1; exp_words = i; break; end
      exp_data.push_back(w);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                         input int ek, input int ei, input int wm, input bit poke);
    int cyc;
    bit seen;
    logic [31:0] da;
    da = {d[31:2], 2'b00};
    prep_job(s, d, n, ek, ei, wm);
    @(negedge HCLK);
    src_addr = s; dst_addr = d; len = LEN_W'(n); start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    cyc = 1; seen = 0;
    while (cyc < 2000) begin
      if (done) begin seen = 1; break; end
      chk("busy_during_job", 64'(busy), 64'd1);
      if (poke && cyc == 3) begin
        start = 1'b1; src_addr = $urandom; dst_addr = $urandom; len = LEN_W'(7);
      end else begin
        start = 1'b0;
      end
      @(negedge HCLK);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    if (!exp_err && wm == 0) chk("done_cycle_zero_wait", 64'(cyc), 64'(4 * n + 1));
    if (!exp_err && wm == 1) chk("done_cycle_two_wait", 64'(cyc), 64'(8 * n + 1));
    chk("busy_in_fin", 64'(busy), 64'd0);
    chk("error_flag", 64'(error), 64'(exp_err));
    chk("words_done", 64'(words_done), 64'(exp_words));
    chk("all_transfers_seen", 64'(exp_q.size()), 64'd0);
    @(negedge HCLK);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("error_sticky", 64'(error), 64'(exp_err));
    for (int i = 0; i < exp_words; i++)
      chk("dst_mem", 64'(mem_rd(da + 32'(4 * i))), 64'(exp_data[i]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    chk("rst_htrans", 64'(HTRANS), 64'd0);
    chk("rst_haddr", 64'(HADDR), 64'd0);
    chk("rst_hwrite", 64'(HWRITE), 64'd0);
    chk("rst_hwdata", 64'(HWDATA), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_words_done", 64'(words_done), 64'd0);
    chk("const_hsize", 64'(HSIZE), 64'd2);
    chk("const_hburst", 64'(HBURST), 64'd0);
    chk("const_hmastlock", 64'(HMASTLOCK), 64'd0);
    chk("const_hprot", 64'(HPROT), 64'd3);
    repeat (3) @(negedge HCLK);
    #2 HRESET = 1'b0;

    run_job(32'h1F00_0000, 32'h1F10_0000, 3, 0, 0, 0, 0);
    run_job(32'h1F00_0040, 32'h1F10_0040, 1, 0, 0, 1, 0);
    run_job(32'h2000_0000, 32'h2010_0000, 4, 2, 1, 0, 0);   // error on 2nd write
    run_job(32'h2000_0100, 32'h2010_0100, 3, 1, 2, 0, 0);   // error on 3rd read
    run_job(32'h3000_0000, 32'h3010_0000, 0, 0, 0, 0, 0);   // len 0
    run_job(32'h3000_0200, 32'h3010_0200, 3, 0, 0, 0, 1);   // start while busy
    run_job(32'hFFFF_FFFC, 32'h4000_0000, 2, 0, 0, 0, 0);   // source wraps
    run_job(32'h1000_0003, 32'h5000_0002, 1, 0, 0, 0, 0);   // low bits dropped

    for (int j = 0; j < 20; j++) begin
      logic [31:0] s;
      int n, ek;
      s  = $urandom;
      n  = $urandom_range(0, 12);
      ek = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_job(s, s ^ 32'h8000_0000, n, ek, (n > 0) ? int'($urandom_range(0, n - 1)) : 0,
              int'($urandom_range(0, 2)), 0);
    end

    // Reset in the middle of a copy: bus idles immediately, no done afterwards.
    prep_job(32'h6000_0000, 32'h6010_0000, 5, 0, 0, 0);
    @(negedge HCLK);
    src_addr = 32'h6000_0000; dst_addr = 32'h6010_0000; len = LEN_W'(5); start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    repeat (6) @(negedge HCLK);
    chk("pre_reset_words", 64'(words_done), 64'd1);
    #2 HRESET = 1'b1;
    #1;
    chk("midjob_rst_htrans", 64'(HTRANS), 64'd0);
    chk("midjob_rst_busy", 64'(busy), 64'd0);
    chk("midjob_rst_words", 64'(words_done), 64'd0);
    chk("midjob_rst_done", 64'(done), 64'd0);
    @(negedge HCLK);
    exp_q.delete(); wd_q.delete();
    #2 HRESET = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge HCLK);
      chk("no_done_after_reset", 64'(done), 64'd0);
      chk("bus_idle_after_reset", 64'(HTRANS), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
